// File: rtl/mig1_ram_arbiter.sv
// Arbitrates the single-read/single-write Mig1 RAM between instruction fetch and load/store.
// Round-robin read port, LS-owned write port, read-after-write interlock, one-cycle read return.
module mig1_ram_arbiter #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int DATA_WIDTH = DATA_SIZE * 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  req_id_e              rr_last_q, rr_last_d;
  logic                 if_pend_q, if_pend_d;
  logic                 ls_pend_q, ls_pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic ls_wr, ls_rd, if_hazard, if_cand, withheld;

  always_comb begin
    ls_wr         = ls_req_i & ls_we_i;
    ls_rd         = ls_req_i & ~ls_we_i;
    // A write lands at the end of this cycle, so a same-address IF read must wait one cycle.
    if_hazard     = if_req_i & ls_wr & (if_addr_i == ls_addr_i);
    if_cand       = if_req_i & ~if_hazard;

    if_gnt_o      = 1'b0;
    ls_gnt_o      = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_rd_addr_o = if_addr_i;
    ram_wr_en_o   = 1'b0;
    ram_wr_addr_o = ls_addr_i;
    ram_wr_data_o = ls_wdata_i;
    rr_last_d     = rr_last_q;

    if (!rst_i) begin
      if (ls_wr) begin
        ls_gnt_o    = 1'b1;
        ram_wr_en_o = 1'b1;
      end
      if (if_cand && ls_rd) begin
        if (rr_last_q == REQ_LS) if_gnt_o = 1'b1;
        else                     ls_gnt_o = 1'b1;
      end else if (if_cand) begin
        if_gnt_o = 1'b1;
      end else if (ls_rd) begin
        ls_gnt_o = 1'b1;
      end

      if (if_gnt_o) begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = if_addr_i;
        rr_last_d     = REQ_IF;
      end else if (ls_gnt_o && ls_rd) begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = ls_addr_i;
        rr_last_d     = REQ_LS;
      end
    end

    withheld  = (if_req_i & ~if_gnt_o) | (ls_rd & ~ls_gnt_o);
    cnt_d     = cnt_q;
    if (withheld && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;

    if_pend_d = if_gnt_o;
    ls_pend_d = ls_gnt_o & ls_rd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q <= REQ_IF;
      if_pend_q <= 1'b0;
      ls_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      if_pend_q <= if_pend_d;
      ls_pend_q <= ls_pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign if_rvalid_o    = if_pend_q;
  assign ls_rvalid_o    = ls_pend_q;
  assign if_rdata_o     = if_pend_q ? ram_rd_data_i : '0;
  assign ls_rdata_o     = ls_pend_q ? ram_rd_data_i : '0;
  assign conflict_cnt_o = cnt_q;

endmodule
